// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared memory-path definitions for the instruction and data memories:
//   - mem_size_e   : load/store access size encoding (2'b11 is illegal)
//   - dmem_state_e : data-memory controller state (array clear / idle)
//   - MEM_DEPTH_BYTES / MEM_ADDR_W : default array geometry
//   - mem_extend() : sign/zero extension of a left-aligned load value
// -----------------------------------------------------------------------------
package mem_pkg;

   localparam int MEM_DEPTH_BYTES = 2048;
   localparam int MEM_ADDR_W      = 11;

   typedef enum logic [1:0] {
      MEM_B = 2'b00,
      MEM_H = 2'b01,
      MEM_W = 2'b10
   } mem_size_e;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } dmem_state_e;

   // The loaded value arrives left-aligned: a byte sits in [31:24] and a
   // half in [31:16], which keeps the extension independent of the lane.
   function automatic logic [31:0] mem_extend(input logic [31:0] left_al,
                                              input logic [1:0]  size,
                                              input logic        is_unsigned);
      logic [31:0] res;
      case (size)
         MEM_B:   res = is_unsigned ? {24'h000000, left_al[31:24]}
                                    : {{24{left_al[31]}}, left_al[31:24]};
         MEM_H:   res = is_unsigned ? {16'h0000, left_al[31:16]}
                                    : {{16{left_al[31]}}, left_al[31:16]};
         MEM_W:   res = left_al;
         default: res = 32'h0000_0000;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mem_align.sv
// -----------------------------------------------------------------------------
// mem_align
// Combinational lane logic for the big-endian data memory. A memory word is
// four byte lanes; lane 0 (address offset 0) is the MSB of the word and is
// carried on bit 3 of the lane enables and on [31:24] of lane data.
// Ports:
//   size_i      access size (mem_size_e encoding, 2'b11 illegal)
//   addr_lo_i   byte offset within the word (addr[1:0])
//   unsigned_i  zero-extend loads when 1
//   wdata_i     right-aligned store data
//   rword_i     word currently stored at the addressed word index
//   err_o       misaligned or illegal-size access
//   lane_en_o   per-lane store enables (all zero on error)
//   lane_data_o store data replicated onto every lane
//   load_data_o extended load result (zero on error)
// -----------------------------------------------------------------------------
module mem_align
   import mem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic        err_o,
   output logic [3:0]  lane_en_o,
   output logic [31:0] lane_data_o,
   output logic [31:0] load_data_o
);

   logic [31:0] left_al_s;

   // Alignment check, lane enables and lane data for the access size.
   always_comb begin
      err_o       = 1'b1;
      lane_en_o   = 4'b0000;
      lane_data_o = 32'h0000_0000;
      case (size_i)
         MEM_B: begin
            err_o       = 1'b0;
            lane_en_o   = 4'b1000 >> addr_lo_i;
            lane_data_o = {4{wdata_i[7:0]}};
         end
         MEM_H: begin
            err_o       = addr_lo_i[0];
            lane_en_o   = addr_lo_i[1] ? 4'b0011 : 4'b1100;
            lane_data_o = {2{wdata_i[15:0]}};
         end
         MEM_W: begin
            err_o       = (addr_lo_i != 2'b00);
            lane_en_o   = 4'b1111;
            lane_data_o = wdata_i;
         end
         default: begin
            err_o       = 1'b1;
            lane_en_o   = 4'b0000;
            lane_data_o = 32'h0000_0000;
         end
      endcase
      if (err_o) begin
         lane_en_o = 4'b0000;
      end else begin
         lane_en_o = lane_en_o;
      end
   end

   // Shift the addressed lane(s) to the top of the word, then extend.
   always_comb begin
      left_al_s = rword_i << {addr_lo_i, 3'b000};
      if (err_o) begin
         load_data_o = 32'h0000_0000;
      end else begin
         load_data_o = mem_extend(left_al_s, size_i, unsigned_i);
      end
   end

endmodule

// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
// Byte-addressed big-endian read/write data memory for the load/store path.
// After every reset the array is zeroed in hardware one word per cycle
// (DEPTH_BYTES/4 cycles) with req_ready low; afterwards one request is
// accepted per cycle and answered by a registered one-cycle response.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid/ready request handshake (accept on req_valid & req_ready)
//   req_we          1 = store, 0 = load
//   req_size        00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned    zero-extend loads when 1
//   req_addr        byte address
//   req_wdata       right-aligned store data
//   rsp_valid       one-cycle response strobe
//   rsp_rdata       load result, 0 for stores and errors
//   rsp_err         misaligned address or illegal size
// -----------------------------------------------------------------------------
module data_mem
   import mem_pkg::*;
#(
   parameter int DEPTH_BYTES = MEM_DEPTH_BYTES,
   parameter int ADDR_W      = MEM_ADDR_W
`ifdef DATA_MEM_DUMP_EN
   ,
   parameter string DUMP_FILE = "memory_write.hex"
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int WORDS  = DEPTH_BYTES / 4;
   localparam int WIDX_W = ADDR_W - 2;

   dmem_state_e       state_q, state_d;
   logic [WIDX_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;

   logic [7:0]        mem_q [DEPTH_BYTES];

   logic              accept_s;
   logic [WIDX_W-1:0] rd_idx_s;
   logic [31:0]       rd_word_s;
   logic              align_err_s;
   logic [3:0]        lane_en_s;
   logic [31:0]       lane_data_s;
   logic [31:0]       load_data_s;
   logic [3:0]        mem_we_s;
   logic [31:0]       mem_wdata_s;
   logic [WIDX_W-1:0] mem_widx_s;

   assign accept_s = req_valid & req_ready_q;
   assign rd_idx_s = req_addr[ADDR_W-1:2];

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

   // Assemble the addressed word, lane 0 as the most significant byte.
   always_comb begin
      rd_word_s = {mem_q[{rd_idx_s, 2'd0}], mem_q[{rd_idx_s, 2'd1}],
                   mem_q[{rd_idx_s, 2'd2}], mem_q[{rd_idx_s, 2'd3}]};
   end

   mem_align u_align (
      .size_i      (req_size),
      .addr_lo_i   (req_addr[1:0]),
      .unsigned_i  (req_unsigned),
      .wdata_i     (req_wdata),
      .rword_i     (rd_word_s),
      .err_o       (align_err_s),
      .lane_en_o   (lane_en_s),
      .lane_data_o (lane_data_s),
      .load_data_o (load_data_s)
   );

   // Next state: walk the clear counter, then sit in IDLE serving requests.
   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      case (state_q)
         ST_CLEAR: begin
            if (clr_cnt_q == WIDX_W'(WORDS - 1)) begin
               state_d   = ST_IDLE;
               clr_cnt_d = '0;
            end else begin
               state_d   = ST_CLEAR;
               clr_cnt_d = clr_cnt_q + WIDX_W'(1);
            end
         end
         ST_IDLE: begin
            state_d   = ST_IDLE;
            clr_cnt_d = clr_cnt_q;
         end
         default: begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
         end
      endcase
      req_ready_d = (state_d == ST_IDLE);
   end

   // Response registers: every accepted request answers in the next cycle.
   always_comb begin
      rsp_valid_d = accept_s;
      rsp_err_d   = accept_s & align_err_s;
      if (accept_s && !req_we && !align_err_s) begin
         rsp_rdata_d = load_data_s;
      end else begin
         rsp_rdata_d = 32'h0000_0000;
      end
   end

   // Array write port: the clear sweep owns it in CLEAR, stores in IDLE.
   always_comb begin
      mem_we_s    = 4'b0000;
      mem_wdata_s = 32'h0000_0000;
      mem_widx_s  = rd_idx_s;
      if (state_q == ST_CLEAR) begin
         mem_we_s    = 4'b1111;
         mem_wdata_s = 32'h0000_0000;
         mem_widx_s  = clr_cnt_q;
      end else if (accept_s && req_we) begin
         mem_we_s    = lane_en_s;
         mem_wdata_s = lane_data_s;
         mem_widx_s  = rd_idx_s;
      end else begin
         mem_we_s    = 4'b0000;
         mem_wdata_s = 32'h0000_0000;
         mem_widx_s  = rd_idx_s;
      end
   end

   // Control and response flops; reset restarts the clear from word 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_CLEAR;
         clr_cnt_q   <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Byte array storage; deliberately not reset, the clear sweep zeroes it.
   always_ff @(posedge clk) begin
      if (mem_we_s[3]) mem_q[{mem_widx_s, 2'd0}] <= mem_wdata_s[31:24];
      if (mem_we_s[2]) mem_q[{mem_widx_s, 2'd1}] <= mem_wdata_s[23:16];
      if (mem_we_s[1]) mem_q[{mem_widx_s, 2'd2}] <= mem_wdata_s[15:8];
      if (mem_we_s[0]) mem_q[{mem_widx_s, 2'd3}] <= mem_wdata_s[7:0];
   end

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [10:0] req_addr = 11'h000;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } exp_t;

   logic [7:0] model_m [2048];
   exp_t       exp_q [$];
   exp_t       mon_e;
   int         n_checks = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   data_mem dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: byte-array memory, big-endian, rules applied directly.
   function automatic exp_t model_access(input logic we, input logic [1:0] size,
                                         input logic uns, input logic [10:0] a,
                                         input logic [31:0] wd);
      exp_t        r;
      int          n;
      logic [31:0] raw;
      r.err  = (size == 2'd3) || (size == 2'd1 && a[0]) ||
               (size == 2'd2 && a[1:0] != 2'd0);
      r.data = 32'h0;
      if (!r.err) begin
         n = 1 << size;
         if (we) begin
            for (int i = 0; i < n; i++) model_m[a + i] = 8'(wd >> (8 * (n - 1 - i)));
         end else begin
            raw = 32'h0;
            for (int i = 0; i < n; i++) raw = (raw << 8) | 32'(model_m[a + i]);
            if (!uns && n < 4 && raw[8 * n - 1]) raw = raw | (32'hFFFF_FFFF << (8 * n));
            r.data = raw;
         end
      end
      return r;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 2048; i++) model_m[i] = 8'h00;
   endfunction

   // Issue one request at a falling edge; expected response comes from the model.
   task automatic req(input logic we, input logic [1:0] size, input logic uns,
                      input logic [10:0] a, input logic [31:0] wd);
      check("req_ready", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_size = size;
      req_unsigned = uns; req_addr = a; req_wdata = wd;
      exp_q.push_back(model_access(we, size, uns, a, wd));
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Same as req, but the expected response is a hand-derived constant.
   task automatic req_k(input logic we, input logic [1:0] size, input logic uns,
                        input logic [10:0] a, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_data);
      exp_t e;
      check("req_ready", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_size = size;
      req_unsigned = uns; req_addr = a; req_wdata = wd;
      e = model_access(we, size, uns, a, wd);
      e.err = exp_err;
      e.data = exp_data;
      exp_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Count rising edges from reset release until req_ready rises, with a bound.
   task automatic wait_ready(input int exp_cycles);
      int cnt = 0;
      while (req_ready !== 1'b1 && cnt < 2000) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      req_valid = 1'b0;
      check("clear_cycles", 32'(cnt), 32'(exp_cycles));
      @(negedge clk);
   endtask

   // Requests driven during the clear must be ignored.
   task automatic drive_junk();
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
      req_unsigned = 1'b0; req_addr = 11'h100; req_wdata = 32'hFFFF_FFFF;
   endtask

   // Monitor: pop and compare whenever the DUT presents a response.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response (t=%0t)", $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
            check("rsp_rdata", rsp_rdata, mon_e.data);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        we;
      logic [1:0]  sz;
      logic        un;
      logic [10:0] ad;

      model_clear();
      #2 rst_n = 1'b0;
      #1;
      check("rst_ready", {31'b0, req_ready}, 32'd0);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      repeat (3) @(negedge clk);
      drive_junk();
      rst_n = 1'b1;
      wait_ready(512);

      req_k(1'b0, 2'd2, 1'b0, 11'h100, 32'h0, 1'b0, 32'h0000_0000);

      req_k(1'b1, 2'd2, 1'b0, 11'h7FC, 32'hDEAD_BEEF, 1'b0, 32'h0);
      req_k(1'b0, 2'd2, 1'b0, 11'h7FC, 32'h0, 1'b0, 32'hDEAD_BEEF);
      req_k(1'b0, 2'd0, 1'b1, 11'h7FC, 32'h0, 1'b0, 32'h0000_00DE);
      req_k(1'b0, 2'd0, 1'b0, 11'h7FF, 32'h0, 1'b0, 32'hFFFF_FFEF);

      req_k(1'b1, 2'd1, 1'b0, 11'h010, 32'h0000_A55A, 1'b0, 32'h0);
      req_k(1'b0, 2'd1, 1'b0, 11'h010, 32'h0, 1'b0, 32'hFFFF_A55A);
      req_k(1'b0, 2'd1, 1'b1, 11'h010, 32'h0, 1'b0, 32'h0000_A55A);
      req_k(1'b0, 2'd2, 1'b0, 11'h010, 32'h0, 1'b0, 32'hA55A_0000);

      req_k(1'b1, 2'd2, 1'b0, 11'h002, 32'h1234_5678, 1'b1, 32'h0);
      req_k(1'b0, 2'd2, 1'b0, 11'h000, 32'h0, 1'b0, 32'h0000_0000);
      req_k(1'b0, 2'd1, 1'b0, 11'h011, 32'h0, 1'b1, 32'h0);
      req_k(1'b0, 2'd3, 1'b0, 11'h020, 32'h0, 1'b1, 32'h0);
      req_k(1'b1, 2'd3, 1'b0, 11'h020, 32'hFFFF_FFFF, 1'b1, 32'h0);
      idle(2);

      // Back-to-back store then load of the same word.
      req_k(1'b1, 2'd2, 1'b0, 11'h020, 32'hCAFE_F00D, 1'b0, 32'h0);
      check("b2b_valid_k1", {31'b0, rsp_valid}, 32'd1);
      req_k(1'b0, 2'd2, 1'b0, 11'h020, 32'h0, 1'b0, 32'hCAFE_F00D);
      check("b2b_valid_k2", {31'b0, rsp_valid}, 32'd1);
      idle(1);
      check("b2b_valid_drop", {31'b0, rsp_valid}, 32'd0);

      // Randomized traffic, concentrated on a small window for reuse.
      for (int i = 0; i < 400; i++) begin
         we = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         un = 1'($urandom_range(0, 1));
         ad = ($urandom_range(0, 4) == 0) ? 11'($urandom_range(0, 2047))
                                          : 11'($urandom_range(0, 63));
         req(we, sz, un, ad, $urandom);
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(2);

      // Reset while a response is pending: rsp_valid falls without a clock edge.
      req_k(1'b1, 2'd2, 1'b0, 11'h040, 32'h1111_1111, 1'b0, 32'h0);
      check("midop_valid_before", {31'b0, rsp_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midop_valid_async", {31'b0, rsp_valid}, 32'd0);
      check("midop_ready_async", {31'b0, req_ready}, 32'd0);
      check("midop_queue_empty", 32'(exp_q.size()), 32'd0);
      model_clear();
      repeat (2) @(negedge clk);
      drive_junk();
      rst_n = 1'b1;
      // Abort the clear part-way; it must restart from word 0.
      repeat (100) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("clear_abort_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_ready(512);
      req_k(1'b0, 2'd2, 1'b0, 11'h040, 32'h0, 1'b0, 32'h0000_0000);
      req_k(1'b0, 2'd2, 1'b0, 11'h7FC, 32'h0, 1'b0, 32'h0000_0000);
      req_k(1'b0, 2'd2, 1'b0, 11'h100, 32'h0, 1'b0, 32'h0000_0000);
      for (int i = 0; i < 60; i++) begin
         req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
             11'($urandom_range(0, 31)), $urandom);
      end
      idle(3);
      check("drain_queue", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
